pc_sequencer: RTL and testbench

Instruction sequencer for the picoMIPS core, and the control-side counterpart of the program counter. It consumes the current PC value and the fetched instruction, evaluates ALU flags, and drives the PC increment, absolute-branch and relative-branch controls plus the branch address. It sits between program memory and the PC. It also gates register writes and handles multi-cycle operations and halt.

---
 rtl/pc_seq_pkg.sv | 31 +++
 rtl/ret_stack.sv | 45 ++++
 rtl/pc_sequencer.sv | 159 +++++++++++++++
 tb/tb_pc_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the picoMIPS instruction sequencer.
package pc_seq_pkg;

  // Opcode field position for the default 20-bit instruction word
  localparam int OPC_MSB     = 19;
  localparam int OPC_LSB     = 16;
  localparam int OPC_W       = OPC_MSB - OPC_LSB + 1;
  localparam int STACK_DEPTH = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ALU  = 4'd1,
    OP_MUL  = 4'd2,
    OP_BRA  = 4'd3,
    OP_BEQ  = 4'd4,
    OP_BNE  = 4'd5,
    OP_BLT  = 4'd6,
    OP_HALT = 4'd7,
    OP_CALL = 4'd8,
    OP_RET  = 4'd9
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack for CALL/RET; a push when full overwrites the oldest entry,
// a pop when empty reads as zero and leaves the stack unchanged.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int W     = 6,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q;
  logic [PW:0]   cnt_q;

  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = empty ? '0 : mem_q[wp_q - 1'b1];

  // Circular buffer: when full, wp_q already points at the oldest slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wp_q] <= din;
      wp_q        <= wp_q + 1'b1;
      if (!full) cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      wp_q  <= wp_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer for picoMIPS: decodes IR and drives PC/regfile/multiplier controls.
// Optional return stack enabled by defining PC_CALLSTACK_EN.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// FETCH | latch instr into IR
// EXEC  | decode IR, issue one PC pulse (or start multiplier / halt)
// WAIT  | multiplier busy; exit cycle writes result and increments PC
// HALT  | stopped until reset
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int Psize = 6,
  parameter int Isize = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [Isize-1:0] instr,
  input  logic [Psize-1:0] PCout,
  input  logic             Z,
  input  logic             N,
  input  logic             busy,
  output logic             PCincr,
  output logic             PCabsbranch,
  output logic             PCrelbranch,
  output logic [Psize-1:0] Branchaddr,
  output logic             reg_we,
  output logic             mul_start,
  output logic             halted,
  output logic             err
);

  state_e           state_q, state_d;
  logic [Isize-1:0] ir_q;
  logic             err_q;
  logic             err_set;
  logic [OPC_W-1:0] opc;
  logic [Psize-1:0] ir_addr;

  assign opc     = ir_q[Isize-1 -: OPC_W];
  assign ir_addr = ir_q[Psize-1:0];
  assign err     = err_q;

`ifdef PC_CALLSTACK_EN
  logic             stk_push, stk_pop, stk_full, stk_empty;
  logic [Psize-1:0] stk_dout;
  logic [Psize-1:0] ret_addr;

  assign ret_addr = PCout + 1'b1;

  ret_stack #(.W(Psize), .DEPTH(STACK_DEPTH)) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (ret_addr),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  logic unused_ir;
  assign unused_ir = ^ir_q[Isize-OPC_W-1:Psize];
`else
  // Without the stack the PC value is not needed
  logic unused_ir;
  assign unused_ir = ^{ir_q[Isize-OPC_W-1:Psize], PCout};
`endif

  always_comb begin
    state_d     = state_q;
    PCincr      = 1'b0;
    PCabsbranch = 1'b0;
    PCrelbranch = 1'b0;
    Branchaddr  = '0;
    reg_we      = 1'b0;
    mul_start   = 1'b0;
    halted      = 1'b0;
    err_set     = 1'b0;
`ifdef PC_CALLSTACK_EN
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
`endif
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opc)
          OP_NOP: PCincr = 1'b1;
          OP_ALU: begin
            reg_we = 1'b1;
            PCincr = 1'b1;
          end
          OP_MUL: begin
            mul_start = 1'b1;
            state_d   = ST_WAIT;
          end
          OP_BRA: begin
            PCabsbranch = 1'b1;
            Branchaddr  = ir_addr;
          end
          OP_BEQ: if (Z) begin
            PCrelbranch = 1'b1;
            Branchaddr  = ir_addr;
          end else PCincr = 1'b1;
          OP_BNE: if (!Z) begin
            PCrelbranch = 1'b1;
            Branchaddr  = ir_addr;
          end else PCincr = 1'b1;
          OP_BLT: if (N) begin
            PCrelbranch = 1'b1;
            Branchaddr  = ir_addr;
          end else PCincr = 1'b1;
          OP_HALT: state_d = ST_HALT;
`ifdef PC_CALLSTACK_EN
          OP_CALL: begin
            stk_push    = 1'b1;
            PCabsbranch = 1'b1;
            Branchaddr  = ir_addr;
            err_set     = stk_full;
          end
          OP_RET: begin
            stk_pop     = 1'b1;
            PCabsbranch = 1'b1;
            Branchaddr  = stk_dout;
            err_set     = stk_empty;
          end
`endif
          default: begin
            PCincr  = 1'b1;
            err_set = 1'b1;
          end
        endcase
      end
      ST_WAIT: if (!busy) begin
        reg_we  = 1'b1;
        PCincr  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) ir_q <= instr;
      if (err_set) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; honours PC_CALLSTACK_EN when defined.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, Z, N, busy;
  logic [19:0] instr;
  logic [5:0] pc;
  logic       PCincr, PCabsbranch, PCrelbranch, reg_we, mul_start, halted, err;
  logic [5:0] Branchaddr;
  logic [12:0] ov;
  logic       exp_err;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         c0;

  always #5 clk = ~clk;

  pc_sequencer #(.Psize(6), .Isize(20)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .PCout(pc),
    .Z(Z), .N(N), .busy(busy),
    .PCincr(PCincr), .PCabsbranch(PCabsbranch), .PCrelbranch(PCrelbranch),
    .Branchaddr(Branchaddr), .reg_we(reg_we), .mul_start(mul_start),
    .halted(halted), .err(err)
  );

  assign ov = {PCincr, PCabsbranch, PCrelbranch, reg_we, mul_start, halted, err, Branchaddr};

  // Environment PC register: follows the pulses exactly as the real PC would
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else if (PCincr) pc <= pc + 6'd1;
    else if (PCabsbranch) pc <= Branchaddr;
    else if (PCrelbranch) pc <= pc + Branchaddr;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] v(input logic incr, input logic abs, input logic rel,
                                    input logic we, input logic ms, input logic hl,
                                    input logic [5:0] ba);
    return {incr, abs, rel, we, ms, hl, exp_err, ba};
  endfunction

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [5:0] a);
    return {op, 10'd0, a};
  endfunction

  // Entered at a negedge while in FETCH; returns at the negedge of the next FETCH
  task automatic exec_instr(input string tag, input logic [19:0] word, input logic z,
                            input logic n, input logic [12:0] exp);
    instr = word; Z = z; N = n;
    #1 chk({tag, "/fetch"}, ov, v(0,0,0,0,0,0,6'd0));
    @(negedge clk); #1 chk({tag, "/exec"}, ov, exp);
    @(negedge clk);
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr = '0; Z = 1'b0; N = 1'b0; busy = 1'b0; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs", ov, 13'd0);
    reset = 1'b0;
    @(negedge clk); #1 chk("idle_outputs", ov, 13'd0);
    chk("idle_pc", pc, 6'd0);
    @(negedge clk);
    go();

    exec_instr("alu", mk(4'd1, 6'd0), 0, 0, v(1,0,0,1,0,0,6'd0));
    chk("pc_after_alu", pc, 6'd1);
    exec_instr("beq_taken", mk(4'd4, 6'h3E), 1, 0, v(0,0,1,0,0,0,6'h3E));
    chk("pc_after_beq_taken", pc, 6'd63);
    exec_instr("beq_not", mk(4'd4, 6'h3E), 0, 0, v(1,0,0,0,0,0,6'd0));
    chk("pc_wrap", pc, 6'd0);
    exec_instr("bne_taken", mk(4'd5, 6'h02), 0, 0, v(0,0,1,0,0,0,6'h02));
    exec_instr("blt_taken", mk(4'd6, 6'h3F), 0, 1, v(0,0,1,0,0,0,6'h3F));
    chk("pc_after_blt", pc, 6'd1);
    exec_instr("blt_not", mk(4'd6, 6'h3F), 0, 0, v(1,0,0,0,0,0,6'd0));
    exec_instr("bra", mk(4'd3, 6'h10), 0, 0, v(0,1,0,0,0,0,6'h10));
    chk("pc_after_bra", pc, 6'd16);
    exec_instr("nop", mk(4'd0, 6'h2A), 0, 0, v(1,0,0,0,0,0,6'd0));

    // MUL with busy high for three WAIT cycles
    c0 = cyc;
    instr = mk(4'd2, 6'd0);
    #1 chk("mul/fetch", ov, v(0,0,0,0,0,0,6'd0));
    @(negedge clk); #1 chk("mul/exec", ov, v(0,0,0,0,1,0,6'd0));
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1 chk("mul/wait", ov, v(0,0,0,0,0,0,6'd0));
    end
    @(negedge clk); busy = 1'b0;
    #1 chk("mul/exit", ov, v(1,0,0,1,0,0,6'd0));
    @(negedge clk);
    chk("mul_cycles", cyc - c0, 6);
    chk("pc_after_mul", pc, 6'd18);

`ifdef PC_CALLSTACK_EN
    exec_instr("call1", mk(4'd8, 6'h08), 0, 0, v(0,1,0,0,0,0,6'h08));
    exec_instr("call2", mk(4'd8, 6'h10), 0, 0, v(0,1,0,0,0,0,6'h10));
    exec_instr("call3", mk(4'd8, 6'h18), 0, 0, v(0,1,0,0,0,0,6'h18));
    exec_instr("call4", mk(4'd8, 6'h20), 0, 0, v(0,1,0,0,0,0,6'h20));
    chk("no_err_4deep", err, 1'b0);
    exec_instr("call5", mk(4'd8, 6'h28), 0, 0, v(0,1,0,0,0,0,6'h28));
    exp_err = 1'b1;
    chk("err_on_overflow", err, 1'b1);
    exec_instr("ret1", mk(4'd9, 6'd0), 0, 0, v(0,1,0,0,0,0,6'd33));
    exec_instr("ret2", mk(4'd9, 6'd0), 0, 0, v(0,1,0,0,0,0,6'd25));
    exec_instr("ret3", mk(4'd9, 6'd0), 0, 0, v(0,1,0,0,0,0,6'd17));
    exec_instr("ret4", mk(4'd9, 6'd0), 0, 0, v(0,1,0,0,0,0,6'd9));
    chk("pc_after_ret4", pc, 6'd9);
    exec_instr("ret_empty", mk(4'd9, 6'd0), 0, 0, v(0,1,0,0,0,0,6'd0));
    chk("pc_after_ret_empty", pc, 6'd0);
`else
    exec_instr("call_off", mk(4'd8, 6'h05), 0, 0, v(1,0,0,0,0,0,6'd0));
    exp_err = 1'b1;
    chk("err_after_call_off", err, 1'b1);
    exec_instr("ret_off", mk(4'd9, 6'h05), 0, 0, v(1,0,0,0,0,0,6'd0));
    chk("pc_after_ret_off", pc, 6'd20);
`endif

    // HALT ignores start and issues no pulses
    exec_instr("halt", mk(4'd7, 6'h11), 0, 0, v(0,0,0,0,0,0,6'd0));
    c0 = pc;
    for (int i = 0; i < 20; i++) begin
      start = ~start;
      #1 chk("halt_hold", ov, v(0,0,0,0,0,1,6'd0));
      @(negedge clk);
    end
    start = 1'b0;
    chk("halt_pc_stable", pc, c0[5:0]);
    reset = 1'b1; exp_err = 1'b0;
    #1 chk("reset_from_halt", ov, 13'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1 chk("idle_after_halt", ov, 13'd0);
    go();

    // Illegal opcode: acts as NOP, err sticky afterwards
    exec_instr("illegal12", mk(4'd12, 6'h07), 0, 0, v(1,0,0,0,0,0,6'd0));
    exp_err = 1'b1;
    chk("err_after_illegal", err, 1'b1);
    exec_instr("alu_after_err", mk(4'd1, 6'd0), 0, 0, v(1,0,0,1,0,0,6'd0));
    exec_instr("bra_after_err", mk(4'd3, 6'h05), 0, 0, v(0,1,0,0,0,0,6'h05));
    chk("pc_after_bra_err", pc, 6'd5);

    // Reset mid-WAIT aborts with no pulse
    instr = mk(4'd2, 6'd0);
    @(negedge clk); #1 chk("mul2/exec", ov, v(0,0,0,0,1,0,6'd0));
    busy = 1'b1;
    @(negedge clk);
    reset = 1'b1; exp_err = 1'b0;
    #1 chk("reset_mid_wait", ov, 13'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1 chk("idle_after_wait_reset", ov, 13'd0);
    busy = 1'b0;
    @(negedge clk); #1 chk("idle_stays", ov, 13'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
